// File: rtl/dm_arb_pkg.sv
// Shared types and width helpers for the data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Owner / pointer index width; a two-core system still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Latency counter holds MEM_LAT-1 at most.
    function automatic int cnt_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/dm_arb_if.sv
// Core-side request bus and data-memory port bundled for the arbiter.
interface dm_arb_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
);
    logic [NUM_CORES-1:0]             core_req;
    logic [NUM_CORES-1:0]             core_we;
    logic [NUM_CORES-1:0][ADDR_W-1:0] core_addr;
    logic [NUM_CORES-1:0][DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]             core_gnt;
    logic [NUM_CORES-1:0]             core_done;
    logic [DATA_W-1:0]                core_rdata;
    logic                             mem_en;
    logic                             mem_we;
    logic [ADDR_W-1:0]                mem_addr;
    logic [DATA_W-1:0]                mem_wdata;
    logic [DATA_W-1:0]                mem_rdata;

    // Arbiter side.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata, mem_rdata,
        output core_gnt, core_done, core_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    // Cores plus memory side.
    modport master (
        output core_req, core_we, core_addr, core_wdata, mem_rdata,
        input  core_gnt, core_done, core_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_arbiter_rr_picker.sv
// Round-robin pick: first eligible request scanning upward from ptr, wrapping.
module rr_picker
    import dm_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);
    logic [N-1:0] elig;

    assign elig = req & ~mask;

    // Linear scan of N positions starting at ptr; first hit wins.
    always_comb begin
        logic [IW:0] pos;
        vld = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N))
                pos = pos - (IW+1)'(N);
            if (!vld && elig[pos[IW-1:0]]) begin
                vld = 1'b1;
                idx = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin sharing of the single data-memory port among the cores:
// one access at a time, fixed memory latency, one-cycle done pulse.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    dm_arb_if.slave  bus
);
    localparam int IW = idx_w(NUM_CORES);
    localparam int CW = cnt_w(MEM_LAT);

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_CORES-1:0] gnt_q, gnt_d;
    logic [NUM_CORES-1:0] done_q, done_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 en_q, en_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    logic [IW-1:0]        next_ptr, pick_ptr, pick_idx;
    logic [NUM_CORES-1:0] pick_mask;
    logic                 pick_vld, take;

    // In RESP the pointer has already moved past the owner, and the owner
    // is masked so it cannot be re-granted straight away.
    assign next_ptr = (owner_q == IW'(NUM_CORES-1)) ? '0 : owner_q + 1'b1;
    assign pick_ptr = (state_q == RESP) ? next_ptr : rr_q;

    // Owner mask applies only during the RESP re-arbitration.
    always_comb begin
        pick_mask = '0;
        if (state_q == RESP)
            pick_mask[owner_q] = 1'b1;
    end

    rr_picker #(.N(NUM_CORES)) u_pick (
        .req  (bus.core_req),
        .mask (pick_mask),
        .ptr  (pick_ptr),
        .vld  (pick_vld),
        .idx  (pick_idx)
    );

    assign take = pick_vld && (state_q == IDLE || state_q == RESP);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latched command, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state and next register values; outputs are computed one cycle
    // ahead so every core/memory output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        en_d    = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: ;
            ISSUE: begin
                cnt_d   = CW'(MEM_LAT-1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q)
                        rdata_d = bus.mem_rdata;
                    done_d[owner_q] = 1'b1;
                    state_d         = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rr_d    = next_ptr;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A winner in IDLE or RESP latches its command and goes to ISSUE.
        if (take) begin
            owner_d           = pick_idx;
            we_d              = bus.core_we[pick_idx];
            addr_d            = bus.core_addr[pick_idx];
            wdata_d           = bus.core_wdata[pick_idx];
            en_d              = 1'b1;
            gnt_d             = '0;
            gnt_d[pick_idx]   = 1'b1;
            state_d           = ISSUE;
        end
    end

    assign bus.core_gnt   = gnt_q;
    assign bus.core_done  = done_q;
    assign bus.core_rdata = rdata_q;
    assign bus.mem_en     = en_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Round-robin arbiter that shares the single data-memory port among the cores of the multi-core processor. Each core raises a request with a command (read or write, address, write data). The arbiter grants one core at a time, issues a single memory access, waits the fixed memory latency, and returns read data with a one-cycle done pulse. It sits between the per-core control units and the data memory that drives DM_out onto each core's bus.

## Interface
- NUM_CORES, 4: number of requesting cores (≥2).
- ADDR_W, 16: memory address width.
- DATA_W, 16: memory data width.
- MEM_LAT, 2: cycles from the mem_en cycle to mem_rdata valid (≥1).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- core_req  in  NUM_CORES  per-core access request.
- core_we  in  NUM_CORES  per-core write (1) / read (0).
- core_addr  in  NUM_CORES*ADDR_W  packed addresses; core i uses slice i.
- core_wdata  in  NUM_CORES*DATA_W  packed write data.
- core_gnt  out  NUM_CORES  one-hot grant, registered.
- core_done  out  NUM_CORES  one-cycle completion pulse, registered.
- core_rdata  out  DATA_W  read data shared by all cores, registered.
- mem_en  out  1  memory access strobe (one-cycle pulse).
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

## Operation
- FSM states:
  - IDLE: arbitrate. If any core_req is set, latch the winner index, we, addr and wdata, then go to ISSUE.
  - ISSUE (1 cycle): assert mem_en. Drive mem_we, mem_addr and mem_wdata from the latched command. Load cnt = MEM_LAT-1. Go to WAIT.
  - WAIT: decrement cnt each cycle. When cnt==0, capture mem_rdata into core_rdata (reads only) and go to RESP.
  - RESP (1 cycle): pulse core_done[owner]. Set rr_ptr = (owner+1) mod NUM_CORES. Arbitrate again with the owner's request masked. On a winner, go directly to ISSUE; otherwise go to IDLE.
- Arbitration: the winner is the first set bit of the request vector, scanning from rr_ptr upward and wrapping at NUM_CORES.
- core_gnt[owner] is high from ISSUE through RESP inclusive. It is zero in IDLE.
- Commands are latched at arbitration. Core-side input changes after that point are ignored.
- Dropping core_req mid-transaction does not abort it; the transaction completes normally.
- A write leaves core_rdata unchanged.
- mem_we, mem_addr and mem_wdata hold their latched values while the transaction is in flight. They are don't-care while mem_en=0.
- Reset values: state IDLE, rr_ptr 0, core_gnt 0, core_done 0, core_rdata 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Reset asserted mid-transaction: all of the above take their reset values on the next edge. No done pulse is produced, and the in-flight access is abandoned.

## Timing
- Request seen in IDLE at cycle 0: ISSUE at cycle 1, WAIT at cycles 2..1+MEM_LAT, RESP/done at cycle 2+MEM_LAT.
- Back-to-back transactions (another request pending in RESP): the next ISSUE is at RESP+1. Steady-state period is MEM_LAT+2 cycles per access.
- Owner still requesting in RESP with no other requester: goes to IDLE and is re-granted with ISSUE two cycles after RESP.
- core_rdata is valid in the RESP cycle and stays stable until the next read capture.

## Structure
- Shared package dm_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the owner-index width function clog2(NUM_CORES);
  - the counter width derived from MEM_LAT.
- Sub-module rr_picker: combinational; takes req vector, ptr and mask, and outputs valid plus winner index. It is instantiated once and used in both IDLE and RESP.

## Test plan
Defaults for all scenarios: NUM_CORES=4, MEM_LAT=2, memory model with exact latency; cycle 0 is the cycle a request is first seen.
- Single read: core 1 reads 0x0040, memory holds 0xBEEF, request at cycle 0.
  - core_gnt=0010 and mem_en with mem_addr=0x0040 at cycle 1.
  - core_done[1] and core_rdata=0xBEEF at cycle 4.
- Single write: core 2 writes 0x1234 to 0x0010.
  - mem_en=mem_we=1 for exactly cycle 1 with mem_wdata=0x1234.
  - core_done[2] at cycle 4; core_rdata unchanged.
- Full contention: all four request at cycle 0 with rr_ptr=0.
  - ISSUE for cores 0, 1, 2, 3 at cycles 1, 5, 9, 13.
  - Done pulses at cycles 4, 8, 12, 16.
- Owner masking: core 3 is the only requester and holds req high through done.
  - Not re-granted in RESP (cycle 4); IDLE at cycle 5; second ISSUE at cycle 6.
- Pointer wrap: after core 3 completes, cores 0 and 3 request together.
  - Core 0 is served first, then core 3.
- Reset mid-WAIT: rst_n low during cycle 2.
  - At cycle 3 all outputs are 0 and no done ever pulses.
  - After release, a new core 0 read completes with standard timing.
